line_memory_responder: RTL and testbench
========================================

LINE_MEMORY_RESPONDER -- requirements
Module: line_memory_responder

Interface
REQ-001 Parameter LATENCY, default 10, cycles from request capture to ack; legal range 2..255.
REQ-002 Parameter DEPTH_LOG2, default 9, log2 of line count (512 lines x 256 bits = 16 KB).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 addr_i  input  32  byte address of request.
REQ-006 data_i  input  256  write line data.
REQ-007 enable_i  input  1  request valid, held by initiator until ack_o.
REQ-008 write_i  input  1  1 = write line, 0 = read line.
REQ-009 ack_o  output  1  one-cycle completion pulse, registered.
REQ-010 data_o  output  256  read line data, registered.
REQ-011 busy_o  output  1  high while a request is in flight (WAIT or ACK).

Function
REQ-012 The block SHALL be the memory-side responder to the dcache line interface: one outstanding request, no pipelining.
REQ-013 Storage SHALL be 2^DEPTH_LOG2 lines of 256 bits, indexed by addr_i[5+DEPTH_LOG2-1:5].
REQ-014 addr_i[4:0] SHALL be ignored; addr_i bits above the index SHALL be ignored (aliasing wrap-around, no error).
REQ-015 FSM states SHALL be IDLE, WAIT, ACK.
REQ-016 IDLE: on a rising edge with enable_i=1, the block SHALL capture addr_i, data_i and write_i, load the counter with LATENCY-1, and enter WAIT.
REQ-017 IDLE with enable_i=0 SHALL stay IDLE with no side effects.
REQ-018 WAIT: the counter SHALL decrement each cycle; on the edge where it reaches 1, the block SHALL enter ACK.
REQ-019 ack_o SHALL be high exactly in the ACK-state cycle, which is LATENCY cycles after the capture edge.
REQ-020 Writes: the captured line SHALL be committed to storage at the edge entering ACK.
REQ-021 Reads: data_o SHALL be loaded from storage at the edge entering ACK.
REQ-022 data_o SHALL hold its value otherwise and SHALL be unchanged by writes.
REQ-023 ACK: the block SHALL return to IDLE on the next edge unconditionally.
REQ-024 enable_i in the ACK cycle SHALL be ignored; a new request is accepted at the earliest one cycle after ack_o.
REQ-025 Changes to addr_i, data_i, write_i or enable_i during WAIT/ACK SHALL be ignored; captured values are used.
REQ-026 enable_i dropped during WAIT SHALL NOT abort the request; ack_o still pulses.
REQ-027 busy_o SHALL be 1 in WAIT and ACK, 0 in IDLE.
REQ-028 A read following a write to the same line SHALL return the written data (write committed before the next capture).

Reset
REQ-029 With rst_i high: state=IDLE, counter=0, ack_o=0, busy_o=0, data_o=0, independent of clock.
REQ-030 Reset mid-operation SHALL abort the request with no ack_o and no storage write (the write commits only at ACK entry).
REQ-031 Reset SHALL NOT clear storage contents.
REQ-032 A request with enable_i high at the first edge after rst_i falls SHALL be accepted normally.

Verification
REQ-033 Write 0xA5 pattern line to addr 0x0000_0040, then read 0x0000_0040 -> ack_o pulses 10 cycles after each capture; read data_o = write line.
REQ-034 Write line X to 0x0000_0020, read 0x0000_4020 (DEPTH_LOG2=9) -> data_o = X (alias wrap).
REQ-035 Read with addr_i[4:0]=0x1F vs 0x00 on the same line -> identical data_o.
REQ-036 Hold enable_i high continuously across two reads -> ack_o pulses at capture+10 and again at capture2+10, where capture2 is one cycle after the first ack; no back-to-back acks.
REQ-037 Start write of Y to line 3, assert rst_i at cycle 5, then read line 3 -> no ack_o for the aborted write; line 3 holds its old value; data_o = 0 after reset until the read acks.
REQ-038 With LATENCY=2, issue a read -> ack_o at capture+2; busy_o high for exactly 2 cycles.

Source files
------------

// File: rtl/line_memory_responder_if.sv
// Line-transfer bus between a dcache line port (master) and the memory-side responder (slave).
// Carries a single request/ack handshake: the master holds enable_i until ack_o pulses.
interface line_memory_responder_if;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         enable_i;
    logic         write_i;
    logic         ack_o;
    logic [255:0] data_o;
    logic         busy_o;

    modport master (
        output addr_i, data_i, enable_i, write_i,
        input  ack_o, data_o, busy_o
    );

    modport slave (
        input  addr_i, data_i, enable_i, write_i,
        output ack_o, data_o, busy_o
    );
endinterface

// File: rtl/line_memory_responder.sv
// Memory-side responder for 256-bit line requests.
// Handles one request at a time and acknowledges it a fixed LATENCY cycles after capture.
module line_memory_responder #(
    parameter int unsigned LATENCY    = 10,
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    line_memory_responder_if.slave  bus
);
    localparam int unsigned LINES = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [255:0]            wdata_q;
    logic                    write_q;
    logic                    ack_q;
    logic [255:0]            data_q;
    logic                    capture;
    logic                    enter_ack;
    logic                    busy;

    logic [255:0] mem_q [LINES];

    // Offset bits and address bits above the index simply alias onto the line array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr_i[31:5+DEPTH_LOG2], bus.addr_i[4:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.enable_i) begin
                    state_d = S_WAIT;
                    cnt_d   = 8'(LATENCY - 1);
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        capture   = (state_q == S_IDLE) && bus.enable_i;
        enter_ack = (state_q == S_WAIT) && (cnt_q == 8'd1);
        busy      = (state_q != S_IDLE);
    end

    // Request fields are only meaningful once captured, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            idx_q   <= bus.addr_i[5+DEPTH_LOG2-1:5];
            wdata_q <= bus.data_i;
            write_q <= bus.write_i;
        end
    end

    // Storage survives reset; a write lands only on the edge that enters ACK.
    always_ff @(posedge clk_i) begin
        if (enter_ack && write_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q  <= 1'b0;
            data_q <= '0;
        end else begin
            ack_q <= enter_ack;
            if (enter_ack && !write_q) begin
                data_q <= mem_q[idx_q];
            end
        end
    end

    assign bus.ack_o  = ack_q;
    assign bus.data_o = data_q;
    assign bus.busy_o = busy;
endmodule

// File: tb/tb_line_memory_responder.sv
// Randomized self-checking bench for line_memory_responder: a LATENCY=10 and a LATENCY=2
// instance share the same request stream and are compared against a line-array model.
module tb_line_memory_responder;
    localparam int L1 = 10;
    localparam int L2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_memory_responder_if m ();
    line_memory_responder_if m2 ();

    assign m2.addr_i   = m.addr_i;
    assign m2.data_i   = m.data_i;
    assign m2.enable_i = m.enable_i;
    assign m2.write_i  = m.write_i;

    line_memory_responder #(.LATENCY(L1), .DEPTH_LOG2(9)) dut (
        .clk_i(clk), .rst_i(rst), .bus(m)
    );
    line_memory_responder #(.LATENCY(L2), .DEPTH_LOG2(9)) dut2 (
        .clk_i(clk), .rst_i(rst), .bus(m2)
    );

    int errors = 0;
    int checks = 0;

    logic [255:0] mem_m [2][512];
    bit           vld   [2][512];
    logic [255:0] rd_m  [2];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One full transaction started at a negedge while both DUTs are idle.
    // Request presented in cycle 0; ack expected in cycle LATENCY.
    task automatic do_req(input bit wr, input logic [31:0] a, input logic [255:0] d);
        int k, k1, k2, b1, b2, acks2;
        int idx;
        logic [255:0] obs [2];
        idx = int'(a[13:5]);
        m.addr_i = a; m.data_i = d; m.write_i = wr; m.enable_i = 1'b1;
        k = 0; k1 = 0; k2 = 0; b1 = 0; b2 = 0; acks2 = 0;
        while (k1 == 0 && k < 300) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                m.enable_i = 1'b0;
                m.addr_i   = $urandom;
                m.data_i   = rnd_line();
                m.write_i  = 1'($urandom);
            end
            if (m.busy_o) b1++;
            if (m2.busy_o) b2++;
            if (m2.ack_o) begin
                acks2++;
                if (k2 == 0) k2 = k;
            end
            if (m.ack_o) k1 = k;
            else check("data_hold", m.data_o, rd_m[0]);
        end
        check("ack_latency", 256'(k1), 256'(L1));
        check("busy_cycles", 256'(b1), 256'(L1));
        check("ack_latency_l2", 256'(k2), 256'(L2));
        check("busy_cycles_l2", 256'(b2), 256'(L2));
        check("ack_count_l2", 256'(acks2), 256'd1);
        obs[0] = m.data_o;
        obs[1] = m2.data_o;
        for (int j = 0; j < 2; j++) begin
            if (wr) begin
                mem_m[j][idx] = d;
                vld[j][idx]   = 1'b1;
                check(j == 0 ? "wr_data_o_unchanged" : "wr_data_o_unchanged_l2", obs[j], rd_m[j]);
            end else if (vld[j][idx]) begin
                rd_m[j] = mem_m[j][idx];
                check(j == 0 ? "rd_data" : "rd_data_l2", obs[j], rd_m[j]);
            end else begin
                rd_m[j] = obs[j];
            end
        end
        $display("txn %s addr=%h line=%0d ack_cycle=%0d", wr ? "WR" : "RD", a, idx, k1);
        @(negedge clk);
        check("idle_ack_low", 256'(m.ack_o), 256'd0);
        check("idle_busy_low", 256'(m.busy_o), 256'd0);
    endtask

    initial begin
        logic [255:0] pat_a5, x_line, w_line, y_line, r0, r1;
        logic [31:0] a;
        int k;

        pat_a5 = {32{8'hA5}};
        rd_m[0] = '0; rd_m[1] = '0;
        for (int i = 0; i < 512; i++) begin vld[0][i] = 1'b0; vld[1][i] = 1'b0; end
        m.addr_i = '0; m.data_i = '0; m.write_i = 1'b0; m.enable_i = 1'b0;

        #1;
        check("rst_ack", 256'(m.ack_o), 256'd0);
        check("rst_busy", 256'(m.busy_o), 256'd0);
        check("rst_data", m.data_o, 256'd0);
        check("rst_data_l2", m2.data_o, 256'd0);
        repeat (3) @(negedge clk);

        // Request already asserted at the first edge after reset release.
        rst = 1'b0;
        do_req(1'b1, 32'h0000_0040, pat_a5);
        do_req(1'b0, 32'h0000_0040, '0);

        x_line = rnd_line();
        do_req(1'b1, 32'h0000_0020, x_line);
        do_req(1'b0, 32'h0000_4020, '0);

        do_req(1'b1, 32'h0000_0080, rnd_line());
        do_req(1'b0, 32'h0000_009F, '0);
        r0 = m.data_o;
        do_req(1'b0, 32'h0000_0080, '0);
        check("offset_ignored", m.data_o, r0);

        // Enable held high across two reads; address switched after the first capture.
        m.addr_i = 32'h0000_0040; m.write_i = 1'b0; m.enable_i = 1'b1;
        for (k = 1; k <= 2 * L1 + 1; k++) begin
            @(negedge clk);
            if (k == 1) m.addr_i = 32'h0000_0020;
            check("held_en_ack", 256'(m.ack_o), 256'(k == L1 || k == 2 * L1 + 1));
            if (k == L1) check("held_en_rd1", m.data_o, pat_a5);
        end
        check("held_en_rd2", m.data_o, x_line);
        $display("txn RD-RD held enable second_ack_cycle=%0d", 2 * L1 + 1);
        m.enable_i = 1'b0;
        repeat (4) @(negedge clk);
        rd_m[0] = x_line;
        rd_m[1] = m2.data_o;

        // Abort a write to line 3 with reset at cycle 5.
        w_line = rnd_line();
        y_line = rnd_line();
        do_req(1'b1, 32'h0000_0060, w_line);
        m.addr_i = 32'h0000_0060; m.data_i = y_line; m.write_i = 1'b1; m.enable_i = 1'b1;
        for (k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) m.enable_i = 1'b0;
            check("abort_no_ack", 256'(m.ack_o), 256'd0);
            check("abort_ack_l2", 256'(m2.ack_o), 256'(k == L2));
        end
        rst = 1'b1;
        #1;
        check("async_rst_busy", 256'(m.busy_o), 256'd0);
        check("async_rst_ack", 256'(m.ack_o), 256'd0);
        check("async_rst_data", m.data_o, 256'd0);
        check("async_rst_data_l2", m2.data_o, 256'd0);
        mem_m[1][3] = y_line;
        rd_m[0] = '0; rd_m[1] = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("txn WR addr=00000060 aborted by reset");
        do_req(1'b0, 32'h0000_0060, '0);

        // Randomized traffic concentrated on a few lines with random alias/offset bits.
        for (int t = 0; t < 40; t++) begin
            a = $urandom;
            a[13:5] = 9'($urandom_range(0, 7));
            do_req(1'($urandom), a, rnd_line());
        end

        r1 = m.data_o;
        check("final_hold", r1, rd_m[0]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end
endmodule
